iotdf_byte_feeder: RTL and testbench

- Upstream stage of IOTDF: accepts 128-bit sensor words on a valid/ready interface and serialises each into 16 bytes on the in_en/iot_in byte interface.
- Honours IOTDF's busy back-pressure.
- Double-buffered (active shift register plus one pending register), so consecutive words stream with no idle cycle.
- Counts words per round and pulses round_done after the last byte of each round.

---
 rtl/iotdf_byte_feeder_if.sv | 23 ++
 rtl/iotdf_byte_feeder.sv | 87 ++++++++
 tb/tb_iotdf_byte_feeder.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iotdf_byte_feeder_if.sv
// Upstream word handshake plus the IOTDF byte port of the byte feeder.
// The master side is the environment: the word source and IOTDF's busy.
interface iotdf_byte_feeder_if #(
  parameter int WORD_W = 128,
  parameter int BYTE_W = 8
);
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_ready;
  logic              busy;
  logic              in_en;
  logic [BYTE_W-1:0] iot_in;

  modport master (
    output word_valid, word_data, busy,
    input  word_ready, in_en, iot_in
  );

  modport slave (
    input  word_valid, word_data, busy,
    output word_ready, in_en, iot_in
  );
endinterface

// File: rtl/iotdf_byte_feeder.sv
// Serialises 128-bit sensor words into IOTDF bytes, MSB first, with one pending
// word buffered behind the active shift register so that words stream gap-free.
module iotdf_byte_feeder #(
  parameter int WORD_W          = 128,
  parameter int BYTE_W          = 8,
  parameter int WORDS_PER_ROUND = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                abort,
  iotdf_byte_feeder_if.slave  bus,
  output logic [2:0]          word_cnt,
  output logic                round_done
);
  localparam int                BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam int                IDX_W          = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0]  LAST_IDX       = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [2:0]        LAST_CNT       = 3'(WORDS_PER_ROUND - 1);

  logic [WORD_W-1:0] act_reg;
  logic [WORD_W-1:0] pend_reg;
  logic              act_vld;
  logic              pend_vld;
  logic [IDX_W-1:0]  byte_idx;
  logic              xfer;
  logic              word_done;
  logic              accept;

  assign bus.word_ready = ~pend_vld;
  assign bus.in_en      = act_vld & ~bus.busy & ~abort;
  assign bus.iot_in     = act_reg[WORD_W-1 -: BYTE_W];

  assign xfer      = bus.in_en;
  assign word_done = xfer & (byte_idx == LAST_IDX);
  // Abort is handled by priority in the register block, so it is not gated here.
  assign accept    = bus.word_valid & ~pend_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_reg    <= '0;
      pend_reg   <= '0;
      act_vld    <= 1'b0;
      pend_vld   <= 1'b0;
      byte_idx   <= '0;
      word_cnt   <= '0;
      round_done <= 1'b0;
    end else if (abort) begin
      act_vld    <= 1'b0;
      pend_vld   <= 1'b0;
      byte_idx   <= '0;
      word_cnt   <= '0;
      round_done <= 1'b0;
    end else begin
      round_done <= 1'b0;
      if (xfer) begin
        act_reg  <= act_reg << BYTE_W;
        byte_idx <= byte_idx + IDX_W'(1);
      end
      if (word_done) begin
        byte_idx <= '0;
        if (word_cnt == LAST_CNT) begin
          word_cnt   <= '0;
          round_done <= 1'b1;
        end else begin
          word_cnt <= word_cnt + 3'd1;
        end
        // Refill the shift register on the completing edge so no bubble appears.
        if (pend_vld) begin
          act_reg  <= pend_reg;
          pend_vld <= 1'b0;
        end else if (accept) begin
          act_reg <= bus.word_data;
        end else begin
          act_vld <= 1'b0;
        end
      end else if (accept) begin
        if (!act_vld) begin
          act_reg <= bus.word_data;
          act_vld <= 1'b1;
        end else begin
          pend_reg <= bus.word_data;
          pend_vld <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_iotdf_byte_feeder.sv
// Scoreboard bench: bytes of every accepted word are queued and popped on each in_en.
module tb_iotdf_byte_feeder;
  localparam int WORD_W = 128;
  localparam int BYTE_W = 8;
  localparam int WPR    = 8;
  localparam int NBYTES = WORD_W / BYTE_W;
  localparam logic [WORD_W-1:0] W1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  logic       clk = 1'b0;
  logic       rst;
  logic       abort;
  logic [2:0] word_cnt;
  logic       round_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_xfer = 0;
  int n_rd = 0;
  int last_xfer_cyc = -1;
  int rd_cyc = -1;
  logic [BYTE_W-1:0] exp_q[$];

  iotdf_byte_feeder_if #(.WORD_W(WORD_W), .BYTE_W(BYTE_W)) bus ();

  iotdf_byte_feeder #(
    .WORD_W(WORD_W),
    .BYTE_W(BYTE_W),
    .WORDS_PER_ROUND(WPR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .abort(abort),
    .bus(bus),
    .word_cnt(word_cnt),
    .round_done(round_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] mk_word(input int k);
    logic [WORD_W-1:0] w;
    for (int j = 0; j < NBYTES; j++) w[WORD_W-1-BYTE_W*j -: BYTE_W] = 8'(k * 16 + j);
    return w;
  endfunction

  // One clock: sample just after the falling edge, update scoreboard, wait for next falling edge.
  task automatic cycle();
    #1;
    if (round_done) begin
      n_rd++;
      rd_cyc = cyc;
    end
    if (bus.in_en) begin
      n_xfer++;
      last_xfer_cyc = cyc;
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("iot_in", bus.iot_in, exp_q.pop_front());
    end
    if (abort) exp_q.delete();
    else if (bus.word_valid && bus.word_ready)
      for (int i = 0; i < NBYTES; i++) exp_q.push_back(bus.word_data[WORD_W-1-BYTE_W*i -: BYTE_W]);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    abort = 1'b0;
    bus.word_valid = 1'b0;
    bus.word_data = '0;
    bus.busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic run_single(input string tag);
    int x0;
    x0 = n_xfer;
    bus.word_valid = 1'b1;
    bus.word_data = W1;
    #1;
    check({tag, "_ready"}, bus.word_ready, 1);
    check({tag, "_idle"}, bus.in_en, 0);
    cycle();
    bus.word_valid = 1'b0;
    bus.word_data = '0;
    for (int i = 0; i < NBYTES; i++) begin
      #1;
      check({tag, "_en"}, bus.in_en, 1);
      if (i == 0) check({tag, "_first"}, bus.iot_in, 8'h00);
      if (i == NBYTES - 1) begin
        check({tag, "_last"}, bus.iot_in, 8'hFF);
        check({tag, "_cnt0"}, word_cnt, 0);
      end
      cycle();
    end
    #1;
    check({tag, "_en_off"}, bus.in_en, 0);
    check({tag, "_cnt1"}, word_cnt, 1);
    check({tag, "_nbytes"}, n_xfer - x0, NBYTES);
    check({tag, "_q_empty"}, exp_q.size(), 0);
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, x0, rd0, budget, first, ready_low, en_seen, b0, acc_cyc;

    // Reset state
    do_reset();
    #1;
    check("rst_ready", bus.word_ready, 1);
    check("rst_en", bus.in_en, 0);
    check("rst_iot", bus.iot_in, 0);
    check("rst_cnt", word_cnt, 0);
    check("rst_rd", round_done, 0);
    cycle();

    // Single word
    run_single("s1");

    // Back-to-back full round
    do_reset();
    k = 0; x0 = n_xfer; rd0 = n_rd; budget = 0; first = -1; ready_low = 0;
    while (budget < 200 && (n_xfer - x0) < WPR * NBYTES) begin
      bus.word_valid = (k < WPR);
      bus.word_data = mk_word(k);
      #1;
      if (!bus.word_ready) ready_low++;
      if (bus.in_en && first < 0) first = cyc;
      if (bus.word_valid && bus.word_ready) k++;
      cycle();
      budget++;
    end
    bus.word_valid = 1'b0;
    check("s2_nbytes", n_xfer - x0, WPR * NBYTES);
    check("s2_words", k, WPR);
    check("s2_no_gap", last_xfer_cyc - first + 1, WPR * NBYTES);
    check("s2_ready_low", ready_low != 0, 1);
    check("s2_no_early_rd", n_rd - rd0, 0);
    #1;
    check("s2_rd", round_done, 1);
    check("s2_cnt", word_cnt, 0);
    check("s2_en_off", bus.in_en, 0);
    cycle();
    check("s2_rd_once", n_rd - rd0, 1);
    check("s2_rd_cyc", rd_cyc, last_xfer_cyc + 1);
    #1;
    check("s2_rd_pulse", round_done, 0);
    cycle();

    // Busy stall after byte 0x66
    do_reset();
    x0 = n_xfer;
    bus.word_valid = 1'b1;
    bus.word_data = W1;
    cycle();
    bus.word_valid = 1'b0;
    repeat (7) cycle();
    bus.busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("s3_stall_en", bus.in_en, 0);
      check("s3_stall_iot", bus.iot_in, 8'h77);
      if (i == 0) check("s3_idx", dut.byte_idx, 7);
      cycle();
    end
    bus.busy = 1'b0;
    #1;
    check("s3_resume_en", bus.in_en, 1);
    check("s3_resume_iot", bus.iot_in, 8'h77);
    budget = 0;
    while (budget < 40 && (n_xfer - x0) < NBYTES) begin
      cycle();
      budget++;
    end
    #1;
    check("s3_nbytes", n_xfer - x0, NBYTES);
    check("s3_q_empty", exp_q.size(), 0);
    check("s3_en_off", bus.in_en, 0);
    check("s3_cnt", word_cnt, 1);
    cycle();

    // Abort mid-round with pend full
    do_reset();
    k = 0; x0 = n_xfer; budget = 0;
    while (budget < 200 && (n_xfer - x0) < 3 * NBYTES + 4) begin
      bus.word_valid = (k < WPR);
      bus.word_data = mk_word(k);
      #1;
      if (bus.word_valid && bus.word_ready) k++;
      cycle();
      budget++;
    end
    check("s4_setup_bytes", n_xfer - x0, 3 * NBYTES + 4);
    abort = 1'b1;
    bus.word_valid = 1'b1;
    bus.word_data = mk_word(k);
    #1;
    check("s4_setup_cnt", word_cnt, 3);
    check("s4_setup_full", bus.word_ready, 0);
    check("s4_abort_en", bus.in_en, 0);
    cycle();
    abort = 1'b0;
    bus.word_valid = 1'b0;
    #1;
    check("s4_en", bus.in_en, 0);
    check("s4_ready", bus.word_ready, 1);
    check("s4_cnt", word_cnt, 0);
    check("s4_rd", round_done, 0);
    cycle();
    x0 = n_xfer;
    bus.word_valid = 1'b1;
    bus.word_data = W1;
    cycle();
    bus.word_valid = 1'b0;
    #1;
    check("s4_restart_en", bus.in_en, 1);
    check("s4_restart_msb", bus.iot_in, 8'h00);
    budget = 0;
    while (budget < 40 && (n_xfer - x0) < NBYTES) begin
      cycle();
      budget++;
    end
    #1;
    check("s4_nbytes", n_xfer - x0, NBYTES);
    check("s4_q_empty", exp_q.size(), 0);
    check("s4_cnt1", word_cnt, 1);
    cycle();

    // Asynchronous reset mid-transfer
    do_reset();
    bus.word_valid = 1'b1;
    bus.word_data = W1;
    cycle();
    cycle();
    bus.word_valid = 1'b0;
    repeat (19) cycle();
    #1;
    check("s5_setup_cnt", word_cnt, 1);
    check("s5_setup_en", bus.in_en, 1);
    #1;
    rst = 1'b1;
    #1;
    check("s5_en", bus.in_en, 0);
    check("s5_cnt", word_cnt, 0);
    check("s5_rd", round_done, 0);
    check("s5_ready", bus.word_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    run_single("s5");

    // Full hold while busy
    do_reset();
    bus.busy = 1'b1;
    k = 0; x0 = n_xfer; en_seen = 0;
    for (int i = 0; i < 40; i++) begin
      bus.word_valid = (k < 3);
      bus.word_data = mk_word(10 + k);
      #1;
      if (bus.in_en) en_seen++;
      if (bus.word_valid && bus.word_ready) k++;
      cycle();
    end
    #1;
    check("s6_accepted", k, 2);
    check("s6_busy_en", en_seen, 0);
    check("s6_ready", bus.word_ready, 0);
    bus.busy = 1'b0;
    b0 = cyc;
    acc_cyc = -1;
    budget = 0;
    while (budget < 100 && (n_xfer - x0) < 3 * NBYTES) begin
      bus.word_valid = (k < 3);
      bus.word_data = mk_word(10 + k);
      #1;
      if (bus.word_valid && bus.word_ready) begin
        if (k == 2) acc_cyc = cyc;
        k++;
      end
      cycle();
      budget++;
    end
    bus.word_valid = 1'b0;
    check("s6_third_acc", acc_cyc, b0 + NBYTES);
    check("s6_nbytes", n_xfer - x0, 3 * NBYTES);
    check("s6_q_empty", exp_q.size(), 0);
    #1;
    check("s6_cnt", word_cnt, 3);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
